// File: rtl/accel_pkg.sv
// Shared types and constants for the systolic array result path.
// Holds the drain state encoding, frame geometry and saturation limits.
package accel_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int NUM_ELEMS = 9;
  localparam int LAST_IDX  = 8;

  function automatic int sat_max(input int out_width);
    return (1 << (out_width - 1)) - 1;
  endfunction

  function automatic int sat_min(input int out_width);
    return -(1 << (out_width - 1));
  endfunction

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: round-half-up arithmetic right shift, then
// saturate the result into a signed OUT_WIDTH value.
module requant_sat
  import accel_pkg::*;
#(
  parameter int RESULT_WIDTH = 16,
  parameter int OUT_WIDTH    = 8,
  parameter int SHIFT        = 4
) (
  input  logic signed [RESULT_WIDTH-1:0] x,
  output logic signed [OUT_WIDTH-1:0]    y
);

  localparam logic signed [RESULT_WIDTH:0] MAX_T = (RESULT_WIDTH+1)'(sat_max(OUT_WIDTH));
  localparam logic signed [RESULT_WIDTH:0] MIN_T = (RESULT_WIDTH+1)'(sat_min(OUT_WIDTH));

  logic signed [RESULT_WIDTH:0] ext;
  logic signed [RESULT_WIDTH:0] t;

  assign ext = {x[RESULT_WIDTH-1], x};

  // One extra bit keeps the rounding add from wrapping at the positive limit.
  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [RESULT_WIDTH:0] HALF = (RESULT_WIDTH+1)'(1) << (SHIFT - 1);
      logic signed [RESULT_WIDTH:0] sum;
      assign sum = ext + HALF;
      assign t   = sum >>> SHIFT;
    end else begin : g_pass
      assign t = ext;
    end
  endgenerate

  always_comb begin
    y = t[OUT_WIDTH-1:0];
    if (t > MAX_T)
      y = MAX_T[OUT_WIDTH-1:0];
    else if (t < MIN_T)
      y = MIN_T[OUT_WIDTH-1:0];
  end

endmodule

// File: rtl/systolic_result_drain.sv
// Captures a 3x3 result frame from the systolic array and streams the
// requantized elements row-major over a valid/ready handshake.
module systolic_result_drain
  import accel_pkg::*;
#(
  parameter int RESULT_WIDTH = 16,
  parameter int OUT_WIDTH    = 8,
  parameter int SHIFT        = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [RESULT_WIDTH-1:0] c00_in,
  input  logic signed [RESULT_WIDTH-1:0] c01_in,
  input  logic signed [RESULT_WIDTH-1:0] c02_in,
  input  logic signed [RESULT_WIDTH-1:0] c10_in,
  input  logic signed [RESULT_WIDTH-1:0] c11_in,
  input  logic signed [RESULT_WIDTH-1:0] c12_in,
  input  logic signed [RESULT_WIDTH-1:0] c20_in,
  input  logic signed [RESULT_WIDTH-1:0] c21_in,
  input  logic signed [RESULT_WIDTH-1:0] c22_in,
  input  logic                           valid_in,
  output logic signed [OUT_WIDTH-1:0]    m_data,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic                           m_last,
  output logic [3:0]                     m_index,
  output logic                           busy,
  output logic                           overrun_err,
  input  logic                           err_clear
);

  state_t state;
  logic signed [RESULT_WIDTH-1:0] frame_buf [NUM_ELEMS];
  logic signed [RESULT_WIDTH-1:0] in_vec    [NUM_ELEMS];
  logic signed [RESULT_WIDTH-1:0] sel;
  logic                           fire;
  logic                           final_beat;

  assign in_vec[0] = c00_in;
  assign in_vec[1] = c01_in;
  assign in_vec[2] = c02_in;
  assign in_vec[3] = c10_in;
  assign in_vec[4] = c11_in;
  assign in_vec[5] = c12_in;
  assign in_vec[6] = c20_in;
  assign in_vec[7] = c21_in;
  assign in_vec[8] = c22_in;

  assign fire       = (state == DRAIN) && m_ready;
  assign final_beat = fire && (m_index == 4'(LAST_IDX));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      m_index     <= '0;
      overrun_err <= 1'b0;
      for (int i = 0; i < NUM_ELEMS; i++) frame_buf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            for (int i = 0; i < NUM_ELEMS; i++) frame_buf[i] <= in_vec[i];
            state   <= DRAIN;
            m_index <= '0;
          end
        end
        DRAIN: begin
          if (final_beat) begin
            m_index <= '0;
            // A frame arriving exactly on the last handshake chains without a bubble.
            if (valid_in)
              for (int i = 0; i < NUM_ELEMS; i++) frame_buf[i] <= in_vec[i];
            else
              state <= IDLE;
          end else if (fire) begin
            m_index <= m_index + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if ((state == DRAIN) && valid_in && !final_beat)
        overrun_err <= 1'b1;
      else if (err_clear)
        overrun_err <= 1'b0;
    end
  end

  assign m_valid = (state == DRAIN);
  assign busy    = m_valid;
  assign m_last  = m_valid && (m_index == 4'(LAST_IDX));
  assign sel     = frame_buf[m_index];

  requant_sat #(
    .RESULT_WIDTH(RESULT_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .SHIFT       (SHIFT)
  ) u_requant (
    .x(sel),
    .y(m_data)
  );

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: frames, requantization corners,
// backpressure, overrun, back-to-back frames and reset mid-drain.
module tb_systolic_result_drain;

  typedef int vec9_t [9];

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] c00_in = '0, c01_in = '0, c02_in = '0;
  logic signed [15:0] c10_in = '0, c11_in = '0, c12_in = '0;
  logic signed [15:0] c20_in = '0, c21_in = '0, c22_in = '0;
  logic               valid_in = 1'b0;
  logic signed [7:0]  m_data;
  logic               m_valid;
  logic               m_ready = 1'b1;
  logic               m_last;
  logic [3:0]         m_index;
  logic               busy;
  logic               overrun_err;
  logic               err_clear = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  systolic_result_drain #(
    .RESULT_WIDTH(16),
    .OUT_WIDTH   (8),
    .SHIFT       (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .c00_in     (c00_in),
    .c01_in     (c01_in),
    .c02_in     (c02_in),
    .c10_in     (c10_in),
    .c11_in     (c11_in),
    .c12_in     (c12_in),
    .c20_in     (c20_in),
    .c21_in     (c21_in),
    .c22_in     (c22_in),
    .valid_in   (valid_in),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .m_index    (m_index),
    .busy       (busy),
    .overrun_err(overrun_err),
    .err_clear  (err_clear)
  );

  always #5 clk = ~clk;

  // Loads the nine result inputs row-major.
  task automatic applyStimulus(input vec9_t v);
    c00_in = 16'(v[0]); c01_in = 16'(v[1]); c02_in = 16'(v[2]);
    c10_in = 16'(v[3]); c11_in = 16'(v[4]); c12_in = 16'(v[5]);
    c20_in = 16'(v[6]); c21_in = 16'(v[7]); c22_in = 16'(v[8]);
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkIdle(input string tag, input int err);
    checkOutput({tag, " m_valid"}, int'(m_valid), 0);
    checkOutput({tag, " busy"}, int'(busy), 0);
    checkOutput({tag, " m_last"}, int'(m_last), 0);
    checkOutput({tag, " overrun_err"}, int'(overrun_err), err);
  endtask

  // Single valid_in pulse; returns at the first negedge after capture.
  task automatic pulseValid();
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  // Checks nine beats starting at the current negedge. stallIdx holds
  // m_ready low for three cycles at that index; pulseIdx raises valid_in
  // during that beat's handshake. Returns one cycle after the last beat.
  task automatic drainFrame(input string tag, input vec9_t exp,
                            input int stallIdx, input int pulseIdx);
    for (int i = 0; i < 9; i++) begin
      checkOutput($sformatf("%s beat%0d m_valid", tag, i), int'(m_valid), 1);
      checkOutput($sformatf("%s beat%0d m_index", tag, i), int'(m_index), i);
      checkOutput($sformatf("%s beat%0d m_data", tag, i), int'(m_data), exp[i]);
      checkOutput($sformatf("%s beat%0d m_last", tag, i), int'(m_last), (i == 8) ? 1 : 0);
      if (i == stallIdx) begin
        m_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          checkOutput($sformatf("%s stall%0d m_valid", tag, s), int'(m_valid), 1);
          checkOutput($sformatf("%s stall%0d m_index", tag, s), int'(m_index), i);
          checkOutput($sformatf("%s stall%0d m_data", tag, s), int'(m_data), exp[i]);
        end
        m_ready = 1'b1;
      end
      if (i == pulseIdx) valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
    end
  endtask

  initial begin
    vec9_t basic_in, basic_exp, corner_in, corner_exp, all16, all32, all2;
    for (int i = 0; i < 9; i++) begin
      basic_in[i]  = 16 * i;
      basic_exp[i] = i;
      all16[i]     = 16;
      all32[i]     = 32;
      all2[i]      = 2;
    end
    corner_in  = '{32767, -32768, 24, -24, 8, -8, 0, 0, 0};
    corner_exp = '{127, -128, 2, -1, 1, 0, 0, 0, 0};

    // Reset values
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkIdle("reset", 0);
    checkOutput("reset m_index", int'(m_index), 0);
    checkOutput("reset m_data", int'(m_data), 0);
    @(negedge clk);
    checkIdle("idle hold", 0);

    $display("[TB] basic frame");
    applyStimulus(basic_in);
    pulseValid();
    drainFrame("basic", basic_exp, -1, -1);
    checkIdle("basic end", 0);
    checkOutput("basic end m_index", int'(m_index), 0);

    $display("[TB] rounding and saturation");
    applyStimulus(corner_in);
    pulseValid();
    drainFrame("round", corner_exp, -1, -1);
    checkIdle("round end", 0);

    $display("[TB] backpressure");
    applyStimulus(basic_in);
    pulseValid();
    drainFrame("stall", basic_exp, 4, -1);
    checkIdle("stall end", 0);

    $display("[TB] overrun then clear");
    applyStimulus(basic_in);
    pulseValid();
    applyStimulus(all16);
    drainFrame("overrun", basic_exp, -1, 3);
    checkIdle("overrun end", 1);
    repeat (2) @(negedge clk);
    checkIdle("overrun no frame", 1);
    err_clear = 1'b1;
    @(negedge clk);
    err_clear = 1'b0;
    checkIdle("err cleared", 0);

    $display("[TB] back-to-back");
    applyStimulus(basic_in);
    pulseValid();
    applyStimulus(all32);
    drainFrame("b2b first", basic_exp, -1, 8);
    drainFrame("b2b second", all2, -1, -1);
    checkIdle("b2b end", 0);

    $display("[TB] reset mid-drain");
    applyStimulus(basic_in);
    pulseValid();
    for (int i = 0; i < 5; i++) @(negedge clk);
    checkOutput("pre-reset m_index", int'(m_index), 5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkIdle("midreset", 0);
    checkOutput("midreset m_index", int'(m_index), 0);
    @(negedge clk);
    checkIdle("midreset hold", 0);
    pulseValid();
    drainFrame("after reset", basic_exp, -1, -1);
    checkIdle("after reset end", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
- Reader end of the 3x3 systolic array result interface.
- Captures the nine parallel signed results when the array pulses its valid, requantizes each one (rounding arithmetic right shift, then saturation), and streams them out row-major over a valid/ready handshake with a last flag.
- Sits between systolic_array_3x3 and the downstream activation/write-back path.

Parameters:
- RESULT_WIDTH, 16, width of each array result (signed).
- OUT_WIDTH, 8, width of each streamed output (signed). Constraint: OUT_WIDTH <= RESULT_WIDTH.
- SHIFT, 4, requantization right-shift amount. Constraint: 0 <= SHIFT < RESULT_WIDTH.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- c00_in..c22_in  in  RESULT_WIDTH each  signed result matrix (nine ports, cRC_in, R = row, C = column).
- valid_in  in  1  one-cycle pulse; results are valid in the same cycle.
- m_data  out  OUT_WIDTH  signed requantized element.
- m_valid  out  1  stream valid.
- m_ready  in  1  downstream ready.
- m_last  out  1  high with element index 8.
- m_index  out  4  element index 0..8, row-major (index = 3*R + C).
- busy  out  1  high while a frame is held or draining.
- overrun_err  out  1  sticky; a frame was dropped.
- err_clear  in  1  clears overrun_err.

Behaviour:
- Reset values: m_valid=0, m_last=0, m_index=0, busy=0, overrun_err=0, m_data=0, capture buffer all 0, state IDLE.
- States:
  - IDLE: valid_in=1 captures all nine inputs into the buffer; next state DRAIN with m_index=0.
  - DRAIN: on each beat (m_valid && m_ready) m_index increments.
  - Handshake at index 8: next state IDLE, m_valid=0 next cycle.
- Latency: valid_in at cycle N -> m_valid=1, m_index=0 at N+1. Minimum frame duration is 9 cycles with m_ready held high.
- Outputs:
  - m_valid = (state==DRAIN). busy = m_valid.
  - m_last = (m_index==8) && m_valid.
  - m_data is the requantized value of buffer[m_index].
- Output paths:
  - No combinational path from m_ready or valid_in to m_valid, m_data, m_last or m_index.
  - m_data, m_index and m_last hold stable while m_valid && !m_ready.
- Back-to-back frames: valid_in in the same cycle as the final-beat handshake captures the new frame. Next cycle: DRAIN, m_index=0, no bubble, overrun_err unchanged.
- Overrun: valid_in in DRAIN in any cycle other than the final-beat handshake:
  - new data discarded, buffer unchanged, current drain continues;
  - overrun_err=1 from the next cycle.
- err_clear:
  - clears overrun_err next cycle;
  - a simultaneous overrun event wins, so overrun_err stays 1.
- Requantization (per element x):
  - SHIFT>0: t = (x + 2^(SHIFT-1)) >>> SHIFT, computed in RESULT_WIDTH+1 bits (round half up, toward +inf).
  - SHIFT=0: t = x.
  - Saturation: t > 2^(OUT_WIDTH-1)-1 -> max; t < -2^(OUT_WIDTH-1) -> min; otherwise t truncated to OUT_WIDTH.
- Reset mid-drain: the frame is abandoned, all outputs return to reset values next cycle, and no partial beats follow.
- m_ready ignored in IDLE. valid_in=0 in IDLE leaves state unchanged.

Decomposition:
- Shared package (accel_pkg):
  - state enum {IDLE, DRAIN};
  - constants NUM_ELEMS=9, LAST_IDX=8;
  - saturation limit helpers as functions of OUT_WIDTH.
- One sub-module: requant_sat, purely combinational, parameterised RESULT_WIDTH/OUT_WIDTH/SHIFT. It implements rounding, shift and saturation and is instantiated once on the muxed buffer element.
- The capture buffer, state register, index counter and error flag live in the top.

Test Plan:
- Basic frame: cRC_in = 16*(3R+C) (0,16,...,128), valid_in pulse, m_ready=1.
  -> m_data 0,1,...,8 on 9 consecutive cycles starting N+1; m_last only with 8; then m_valid=0.
- Rounding/saturation: c00=32767, c01=-32768, c02=24, c10=-24, c11=8, c12=-8, rest 0.
  -> m_data 127, -128, 2, -1, 1, 0, 0, 0, 0.
- Backpressure: basic frame, m_ready=0 for 3 cycles while m_index=4.
  -> m_data=4, m_index=4 held stable; stream resumes with 5; total 12 cycles valid.
- Overrun then clear: second valid_in (all inputs 16) while m_index=3.
  -> first frame completes unchanged (0..8), overrun_err=1, no new frame follows; err_clear pulse -> overrun_err=0.
- Back-to-back: second frame (all inputs 32) pulsed on the index-8 handshake cycle.
  -> next cycle m_index=0, m_data=2, nine beats of 2, overrun_err stays 0.
- Reset mid-drain: rst=1 for one cycle at m_index=5.
  -> next cycle m_valid=0, busy=0, m_index=0; a fresh valid_in afterwards streams correctly from index 0.
